// File: rtl/display_pkg.sv
// Shared types and sizing helpers for the multiplexed 7-segment display scanner.
package display_pkg;

   typedef enum logic [1:0] {SC_IDLE, SC_BLANK, SC_SHOW} scan_state_t;

   // Anode level that keeps a common-anode digit dark.
   localparam logic ANODE_OFF_N = 1'b1;

   // Counter width able to hold the larger of the dwell and blank terminal values.
   function automatic int cnt_width(input int dwell_cycles, input int blank_cycles);
      int longest;
      longest = (dwell_cycles > blank_cycles) ? dwell_cycles : blank_cycles;
      return (longest < 1) ? 1 : $clog2(longest + 1);
   endfunction

   // Digit index width; a single-digit display still gets one index bit.
   function automatic int idx_width(input int num_digits);
      return (num_digits < 2) ? 1 : $clog2(num_digits);
   endfunction

endpackage

// File: rtl/scan_timer.sv
// Up-counter with synchronous clear, a terminal value and a registered terminal-count flag.
// tc is high in exactly the cycles where the count equals the terminal value.
module scan_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             count,
   input  logic [CNT_W-1:0] term,
   output logic             tc
);

   logic [CNT_W-1:0] cnt;

   // Count toward term, saturating there; clear restarts at zero for the next interval.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         cnt <= '0;
         tc  <= 1'b0;
      end else if (clear) begin
         cnt <= '0;
         tc  <= (term == '0);
      end else if (count && !tc) begin
         cnt <= cnt + 1'b1;
         tc  <= ((cnt + 1'b1) == term);
      end
   end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Scans digits with an all-off gap before each, per-digit blanking and a run enable.
module display_scan_mux
   import display_pkg::*;
#(
   parameter  int NUM_DIGITS   = 2,
   parameter  int DWELL_CYCLES = 10000,
   parameter  int BLANK_CYCLES = 100,
   localparam int IDX_W        = idx_width(NUM_DIGITS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [NUM_DIGITS-1:0]   anode_n,
   output logic [3:0]              digit_val,
   output logic [IDX_W-1:0]        digit_idx,
   output logic                    frame_done
);

   localparam int               CNT_W      = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
   localparam logic [CNT_W-1:0] DWELL_TERM = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_TERM = (BLANK_CYCLES == 0) ? '0 : CNT_W'(BLANK_CYCLES - 1);
   // With no gap configured, digits follow each other directly.
   localparam scan_state_t      GAP_STATE  = (BLANK_CYCLES == 0) ? SC_SHOW : SC_BLANK;
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

   scan_state_t             state_q, state_d;
   logic [IDX_W-1:0]        idx_d;
   logic                    timer_clear, timer_count, tc;
   logic [CNT_W-1:0]        timer_term;
   logic                    frame_d;
   logic                    snap;
   logic [NUM_DIGITS-1:0]   anode_d;
   logic [NUM_DIGITS-1:0]   slot_onehot;
   logic [4*NUM_DIGITS-1:0] digits_shifted;

   scan_timer #(.CNT_W(CNT_W)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clear (timer_clear),
      .count (timer_count),
      .term  (timer_term),
      .tc    (tc)
   );

   // Next-state, next-index and timer control for the scan sequence.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a variable unassigned (no latches).
      state_d     = state_q;
      idx_d       = digit_idx;
      timer_clear = 1'b0;
      timer_count = 1'b0;
      frame_d     = 1'b0;
      if (!en) begin
         state_d     = SC_IDLE;
         idx_d       = '0;
         timer_clear = 1'b1;
      end else begin
         unique case (state_q)
            SC_IDLE: begin
               state_d     = GAP_STATE;
               idx_d       = '0;
               timer_clear = 1'b1;
            end
            SC_BLANK: begin
               if (tc) begin
                  state_d     = SC_SHOW;
                  timer_clear = 1'b1;
               end else begin
                  timer_count = 1'b1;
               end
            end
            SC_SHOW: begin
               if (tc) begin
                  idx_d       = (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
                  frame_d     = (digit_idx == LAST_IDX);
                  state_d     = GAP_STATE;
                  timer_clear = 1'b1;
               end else begin
                  timer_count = 1'b1;
               end
            end
            default: begin
               state_d     = SC_IDLE;
               idx_d       = '0;
               timer_clear = 1'b1;
            end
         endcase
      end
   end

   // Terminal value tracks the interval being entered; snapshot on every entry into SHOW.
   always_comb begin
      timer_term     = (state_d == SC_SHOW) ? DWELL_TERM : BLANK_TERM;
      snap           = timer_clear && (state_d == SC_SHOW);
      slot_onehot    = NUM_DIGITS'(1) << idx_d;
      digits_shifted = digits >> {idx_d, 2'b00};
      anode_d        = {NUM_DIGITS{ANODE_OFF_N}};
      if ((state_d == SC_SHOW) && ((blank_mask & slot_onehot) == '0)) begin
         anode_d = ~slot_onehot;
      end
   end

   // State, index and registered outputs; digit_val only reloads when a slot starts.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= SC_IDLE;
         digit_idx  <= '0;
         anode_n    <= {NUM_DIGITS{ANODE_OFF_N}};
         digit_val  <= '0;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         digit_idx  <= idx_d;
         anode_n    <= anode_d;
         frame_done <= frame_d;
         if (snap) begin
            digit_val <= digits_shifted[3:0];
         end
      end
   end

endmodule

// File: tb/tb_display_scan_mux.sv
// Self-checking bench: table-driven scan of a 2-digit display plus sequences for
// a 4-digit gapless display, a 1-digit display and reset during operation.
`timescale 1ns/1ps
module tb_display_scan_mux;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // 2 digits, dwell 4, blank 2
   logic        en_a;
   logic [7:0]  digits_a;
   logic [1:0]  mask_a;
   logic [1:0]  anode_a;
   logic [3:0]  val_a;
   logic [0:0]  idx_a;
   logic        frame_a;

   // 4 digits, dwell 3, no gap
   logic        en_b;
   logic [15:0] digits_b;
   logic [3:0]  mask_b;
   logic [3:0]  anode_b;
   logic [3:0]  val_b;
   logic [1:0]  idx_b;
   logic        frame_b;

   // 1 digit, dwell 2, blank 1
   logic        en_c;
   logic [3:0]  digits_c;
   logic [0:0]  mask_c;
   logic [0:0]  anode_c;
   logic [3:0]  val_c;
   logic [0:0]  idx_c;
   logic        frame_c;

   display_scan_mux #(.NUM_DIGITS(2), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut_a (
      .clk(clk), .reset(reset), .en(en_a), .digits(digits_a), .blank_mask(mask_a),
      .anode_n(anode_a), .digit_val(val_a), .digit_idx(idx_a), .frame_done(frame_a));

   display_scan_mux #(.NUM_DIGITS(4), .DWELL_CYCLES(3), .BLANK_CYCLES(0)) dut_b (
      .clk(clk), .reset(reset), .en(en_b), .digits(digits_b), .blank_mask(mask_b),
      .anode_n(anode_b), .digit_val(val_b), .digit_idx(idx_b), .frame_done(frame_b));

   display_scan_mux #(.NUM_DIGITS(1), .DWELL_CYCLES(2), .BLANK_CYCLES(1)) dut_c (
      .clk(clk), .reset(reset), .en(en_c), .digits(digits_c), .blank_mask(mask_c),
      .anode_n(anode_c), .digit_val(val_c), .digit_idx(idx_c), .frame_done(frame_c));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       en;
      logic [1:0] mask;
      logic [7:0] digits;
      int         reps;
      logic [1:0] anode;
      logic       idx;
      logic [3:0] val;
      logic       frame;
   } vec_t;

   vec_t vecs[24];

   initial begin
      // {en, mask, digits, reps, anode_n, idx, val, frame}; one row per run of identical cycles.
      vecs[0]  = '{1'b1, 2'b00, 8'hA5, 2, 2'b11, 1'b0, 4'h0, 1'b0}; // first gap
      vecs[1]  = '{1'b1, 2'b00, 8'hA5, 4, 2'b10, 1'b0, 4'h5, 1'b0}; // digit 0
      vecs[2]  = '{1'b1, 2'b00, 8'hA5, 2, 2'b11, 1'b1, 4'h5, 1'b0};
      vecs[3]  = '{1'b1, 2'b00, 8'hA5, 4, 2'b01, 1'b1, 4'hA, 1'b0}; // digit 1
      vecs[4]  = '{1'b1, 2'b00, 8'hA5, 1, 2'b11, 1'b0, 4'hA, 1'b1}; // frame end
      vecs[5]  = '{1'b1, 2'b00, 8'hA5, 1, 2'b11, 1'b0, 4'hA, 1'b0};
      vecs[6]  = '{1'b1, 2'b00, 8'hA5, 4, 2'b10, 1'b0, 4'h5, 1'b0};
      vecs[7]  = '{1'b1, 2'b10, 8'hA5, 2, 2'b11, 1'b1, 4'h5, 1'b0}; // digit 1 masked
      vecs[8]  = '{1'b1, 2'b10, 8'hA5, 4, 2'b11, 1'b1, 4'hA, 1'b0};
      vecs[9]  = '{1'b1, 2'b10, 8'hA5, 1, 2'b11, 1'b0, 4'hA, 1'b1};
      vecs[10] = '{1'b1, 2'b00, 8'hA5, 1, 2'b11, 1'b0, 4'hA, 1'b0};
      vecs[11] = '{1'b1, 2'b00, 8'hA5, 2, 2'b10, 1'b0, 4'h5, 1'b0};
      vecs[12] = '{1'b1, 2'b00, 8'hA7, 2, 2'b10, 1'b0, 4'h5, 1'b0}; // mid-dwell change held off
      vecs[13] = '{1'b1, 2'b00, 8'hA7, 2, 2'b11, 1'b1, 4'h5, 1'b0};
      vecs[14] = '{1'b1, 2'b00, 8'hA7, 4, 2'b01, 1'b1, 4'hA, 1'b0};
      vecs[15] = '{1'b1, 2'b00, 8'hA7, 1, 2'b11, 1'b0, 4'hA, 1'b1};
      vecs[16] = '{1'b1, 2'b00, 8'hA7, 1, 2'b11, 1'b0, 4'hA, 1'b0};
      vecs[17] = '{1'b1, 2'b00, 8'hA7, 4, 2'b10, 1'b0, 4'h7, 1'b0}; // new value shows
      vecs[18] = '{1'b1, 2'b00, 8'hA7, 2, 2'b11, 1'b1, 4'h7, 1'b0};
      vecs[19] = '{1'b1, 2'b00, 8'hA7, 2, 2'b01, 1'b1, 4'hA, 1'b0}; // two cycles of digit 1
      vecs[20] = '{1'b0, 2'b00, 8'hA7, 3, 2'b11, 1'b0, 4'hA, 1'b0}; // disabled
      vecs[21] = '{1'b1, 2'b00, 8'hA7, 2, 2'b11, 1'b0, 4'hA, 1'b0}; // full gap on restart
      vecs[22] = '{1'b1, 2'b00, 8'hA7, 4, 2'b10, 1'b0, 4'h7, 1'b0};
      vecs[23] = '{1'b1, 2'b00, 8'hA7, 2, 2'b11, 1'b1, 4'h7, 1'b0};

      reset    = 1'b0;
      en_a     = 1'b1;
      digits_a = 8'hA5;
      mask_a   = 2'b00;
      en_b     = 1'b0;
      digits_b = 16'h1234;
      mask_b   = 4'b0000;
      en_c     = 1'b0;
      digits_c = 4'h9;
      mask_c   = 1'b0;

      // Reset held for three cycles with en high.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("reset%0d A anode/idx/val/frame", i),
               {anode_a, idx_a, val_a, frame_a}, {2'b11, 1'b0, 4'h0, 1'b0});
         check($sformatf("reset%0d B anode_n", i), anode_b, 4'hF);
      end
      reset = 1'b1;

      // Table-driven scan of the 2-digit display.
      for (int i = 0; i < 24; i++) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            en_a     = vecs[i].en;
            mask_a   = vecs[i].mask;
            digits_a = vecs[i].digits;
            @(posedge clk); #1;
            check($sformatf("A row%0d.%0d anode/idx/val/frame", i, r),
                  {anode_a, idx_a, val_a, frame_a},
                  {vecs[i].anode, vecs[i].idx, vecs[i].val, vecs[i].frame});
         end
      end

      // Reset mid-gap with en high: reset wins, then a clean restart.
      reset = 1'b0;
      @(posedge clk); #1;
      check("A midreset anode/idx/val/frame", {anode_a, idx_a, val_a, frame_a}, {2'b11, 1'b0, 4'h0, 1'b0});
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check($sformatf("A restart gap%0d", i), {anode_a, idx_a, val_a, frame_a}, {2'b11, 1'b0, 4'h0, 1'b0});
      end
      @(posedge clk); #1;
      check("A restart digit0", {anode_a, idx_a, val_a, frame_a}, {2'b10, 1'b0, 4'h7, 1'b0});
      en_a = 1'b0;

      // 4 digits back to back, no gap, wrap 3 -> 0 with frame_done.
      en_b = 1'b1;
      for (int e = 1; e <= 26; e++) begin
         int         d;
         logic [3:0] exp_anode;
         logic [3:0] exp_val;
         logic       exp_frame;
         d         = ((e - 1) / 3) % 4;
         exp_anode = 4'b0001 << d;
         exp_anode = ~exp_anode;
         exp_val   = 4'(4 - d);
         exp_frame = (e > 1) && (((e - 1) % 12) == 0);
         @(posedge clk); #1;
         check($sformatf("B cycle%0d anode/idx/val/frame", e),
               {anode_b, idx_b, val_b, frame_b}, {exp_anode, 2'(d), exp_val, exp_frame});
      end
      en_b = 1'b0;

      // Single digit: index pinned at 0, frame_done every slot.
      en_c = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         int         phase;
         logic       exp_anode;
         logic       exp_frame;
         logic [3:0] exp_val;
         phase     = (e - 1) % 3;
         exp_anode = (phase == 0);
         exp_frame = (phase == 0) && (e > 1);
         exp_val   = (e >= 2) ? 4'h9 : 4'h0;
         @(posedge clk); #1;
         check($sformatf("C cycle%0d anode/idx/val/frame", e),
               {anode_c, idx_c, val_c, frame_c}, {exp_anode, 1'b0, exp_val, exp_frame});
      end
      en_c = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
